// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receive deframer with valid/ready holding register
module uart_rx_core #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 urxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(CLK_DIV);
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 rxs_q, rxs_d;
  logic                 rxs_prev_q, rxs_prev_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_ok_q, par_ok_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 fall;
  logic                 bit_end;

  assign fall    = rxs_prev_q & ~rxs_q;
  assign bit_end = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    state_d      = state_q;
    sync1_d      = urxd;
    rxs_d        = sync1_q;
    rxs_prev_d   = rxs_q;
    cnt_d        = cnt_q + CW'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_ok_d     = par_ok_q;
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;

    if (valid_q && rx_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = S_START;
      end
      S_START: begin
        // Mid-point re-check of the start bit rejects short glitches.
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          par_ok_d  = 1'b1;
          state_d   = rxs_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == BW'(DATA_BITS - 1))
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          else
            bit_idx_d = bit_idx_q + BW'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_d    = '0;
          par_ok_d = (rxs_q == ((^shift_q) ^ 1'(PARITY_ODD)));
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HIGH;
          end else if (!par_ok_q) begin
            parity_err_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_IDLE;
            // A full register that is not draining this cycle keeps its byte.
            if (!valid_q || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b1;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      rxs_q        <= rxs_d;
      rxs_prev_q   <= rxs_prev_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - bench for uart_rx_core: 8N1 instance and 8O1 instance
module tb_uart_rx_core;

  localparam int DIV  = 16;
  localparam int HALF = DIV / 2;
  localparam int K_GOOD = 0, K_FE = 1, K_PE = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic urxd0 = 1'b1, urxd1 = 1'b1;
  logic rx_ready = 1'b1;
  logic [7:0] rx_data0, rx_data1;
  logic rx_valid0, rx_valid1, frame_err0, frame_err1;
  logic parity_err0, parity_err1, overrun0, overrun1, busy0, busy1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  uart_rx_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .rstn(rstn), .urxd(urxd0), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .rx_ready(rx_ready), .frame_err(frame_err0), .parity_err(parity_err0),
    .overrun(overrun0), .busy(busy0));

  uart_rx_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u1 (
    .clk(clk), .rstn(rstn), .urxd(urxd1), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .rx_ready(rx_ready), .frame_err(frame_err1), .parity_err(parity_err1),
    .overrun(overrun1), .busy(busy1));

  logic [7:0] o_data [2];
  logic o_valid [2], o_fe [2], o_pe [2], o_ov [2], o_busy [2];
  assign o_data[0] = rx_data0;   assign o_data[1] = rx_data1;
  assign o_valid[0] = rx_valid0; assign o_valid[1] = rx_valid1;
  assign o_fe[0] = frame_err0;   assign o_fe[1] = frame_err1;
  assign o_pe[0] = parity_err0;  assign o_pe[1] = parity_err1;
  assign o_ov[0] = overrun0;     assign o_ov[1] = overrun1;
  assign o_busy[0] = busy0;      assign o_busy[1] = busy1;

  typedef struct {
    int d;
    int done;
    int kind;
    logic [7:0] data;
  } ev_t;
  ev_t evq[$];

  // Model state: holding register and busy window per instance.
  bit mv [2];
  logic [7:0] md [2];
  int bstart [2], bend [2];
  int n_vr [2], n_fe [2], n_pe [2], n_ov [2];
  logic [7:0] last_rx [2];
  bit pv [2];

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s dut%0d cyc=%0d got=0x%0h want=0x%0h", name, d, cyc, act, exp);
    end
  endtask

  initial begin : compare
    bit efe, epe, eov, tr;
    int k;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        efe = 0; epe = 0; eov = 0;
        if (!rstn) begin
          mv[d] = 0; md[d] = '0; bstart[d] = 0; bend[d] = 0;
        end else begin
          tr = mv[d] && rx_ready;
          if (tr) mv[d] = 0;
          k = -1;
          for (int i = 0; i < evq.size(); i++)
            if (k < 0 && evq[i].d == d && evq[i].done == cyc) k = i;
          if (k >= 0) begin
            case (evq[k].kind)
              K_FE: efe = 1;
              K_PE: epe = 1;
              default: begin
                if (!pv[d] || tr || !mv[d]) begin
                  mv[d] = 1; md[d] = evq[k].data;
                end else begin
                  eov = 1;
                end
              end
            endcase
            evq.delete(k);
          end
        end
        chk("rx_valid", d, o_valid[d], mv[d]);
        if (mv[d]) chk("rx_data", d, o_data[d], md[d]);
        chk("frame_err", d, o_fe[d], efe);
        chk("parity_err", d, o_pe[d], epe);
        chk("overrun", d, o_ov[d], eov);
        chk("busy", d, o_busy[d], rstn && cyc >= bstart[d] && cyc < bend[d]);
        if (o_valid[d] && !pv[d]) begin
          n_vr[d]++;
          last_rx[d] = o_data[d];
        end
        pv[d] = o_valid[d];
        if (o_fe[d]) n_fe[d]++;
        if (o_pe[d]) n_pe[d]++;
        if (o_ov[d]) n_ov[d]++;
      end
      if (!rstn) evq.delete();
    end
  end

  task automatic set_line(input int d, input logic v);
    if (d == 0) urxd0 = v; else urxd1 = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; completion lands 3 sync/edge cycles + half bit + one bit per remaining field later.
  task automatic send(input int d, input logic [7:0] b, input logic pbit, input logic stop,
                      input bit expect_evt, input int hold_low);
    int c, nb, done, kind;
    c = cyc;
    nb = (d == 1) ? 10 : 9;
    done = c + 3 + HALF + DIV * nb;
    if (!stop) kind = K_FE;
    else if (d == 1 && pbit != ((^b) ^ 1'b1)) kind = K_PE;
    else kind = K_GOOD;
    if (expect_evt) evq.push_back('{d, done, kind, b});
    bstart[d] = c + 3;
    bend[d] = (kind == K_FE) ? 32'h7fffffff : done;
    set_line(d, 1'b0);
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      set_line(d, b[i]);
      idle(DIV);
    end
    if (d == 1) begin
      set_line(d, pbit);
      idle(DIV);
    end
    set_line(d, stop);
    idle(DIV);
    if (hold_low > 0) begin
      set_line(d, 1'b0);
      idle(hold_low);
    end
    if (!stop) begin
      set_line(d, 1'b1);
      bend[d] = cyc + 3;
    end
  endtask

  task automatic glitch(input int d);
    bstart[d] = cyc + 3;
    bend[d] = cyc + 3 + HALF;
    set_line(d, 1'b0);
    idle(4);
    set_line(d, 1'b1);
    idle(30);
  endtask

  initial begin : stim
    rstn = 1'b0;
    idle(3);
    chk("reset_valid", 0, rx_valid0, 0);
    chk("reset_data", 0, rx_data0, 0);
    chk("reset_busy", 0, busy0, 0);
    rstn = 1'b1;
    idle(10);

    rx_ready = 1'b1;
    send(0, 8'hA5, 1'b0, 1'b1, 1, 0);
    idle(10);
    chk("a5_count", 0, n_vr[0], 1);
    chk("a5_data", 0, last_rx[0], 8'hA5);
    chk("a5_noerr", 0, n_fe[0] + n_pe[0] + n_ov[0], 0);

    glitch(0);
    chk("glitch_novalid", 0, n_vr[0], 1);
    chk("glitch_noerr", 0, n_fe[0], 0);

    send(0, 8'h3C, 1'b0, 1'b0, 1, 40);
    idle(20);
    chk("ferr_count", 0, n_fe[0], 1);
    chk("ferr_novalid", 0, n_vr[0], 1);
    send(0, 8'h55, 1'b0, 1'b1, 1, 0);
    idle(10);
    chk("after_ferr_count", 0, n_vr[0], 2);
    chk("after_ferr_data", 0, last_rx[0], 8'h55);

    send(1, 8'h07, 1'b1, 1'b1, 1, 0);
    idle(10);
    chk("perr_count", 1, n_pe[1], 1);
    chk("perr_novalid", 1, n_vr[1], 0);
    send(1, 8'h07, 1'b0, 1'b1, 1, 0);
    idle(10);
    chk("par_good_count", 1, n_vr[1], 1);
    chk("par_good_data", 1, last_rx[1], 8'h07);

    rx_ready = 1'b0;
    send(0, 8'h11, 1'b0, 1'b1, 1, 0);
    send(0, 8'h22, 1'b0, 1'b1, 1, 0);
    idle(5);
    chk("ovr_count", 0, n_ov[0], 1);
    chk("ovr_held_data", 0, rx_data0, 8'h11);
    chk("ovr_held_valid", 0, rx_valid0, 1);
    rx_ready = 1'b1;
    idle(2);
    chk("ovr_drained", 0, rx_valid0, 0);

    rx_ready = 1'b0;
    send(0, 8'h44, 1'b0, 1'b1, 1, 0);
    fork
      send(0, 8'h22, 1'b0, 1'b1, 1, 0);
      begin
        idle(3 + HALF + DIV * 9 - 1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("coinc_data", 0, rx_data0, 8'h22);
        chk("coinc_valid", 0, rx_valid0, 1);
      end
    join
    idle(5);
    chk("coinc_no_ovr", 0, n_ov[0], 1);
    chk("coinc_count", 0, n_vr[0], 4);

    fork
      send(0, 8'hFF, 1'b0, 1'b1, 0, 0);
      begin
        idle(60);
        rstn = 1'b0;
        #1;
        chk("mid_reset_busy", 0, busy0, 0);
        chk("mid_reset_valid", 0, rx_valid0, 0);
        chk("mid_reset_data", 0, rx_data0, 0);
        chk("mid_reset_err", 0, {frame_err0, parity_err0, overrun0}, 0);
        idle(5);
        rstn = 1'b1;
      end
    join
    idle(10);
    chk("no_partial", 0, n_vr[0], 4);
    send(0, 8'h81, 1'b0, 1'b1, 1, 0);
    idle(10);
    chk("post_reset_count", 0, n_vr[0], 5);
    chk("post_reset_data", 0, last_rx[0], 8'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
